// File: rtl/mailbox_fifo_pkg.sv
// Shared encodings for the mailbox arbiter: mailbox opcodes, handshake FSM
// states and the identity of the two requesting ports.
package mailbox_fifo_pkg;

  typedef enum logic [1:0] {
    OP_PEEK = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10
  } state_t;

  typedef enum logic {
    GRANT_SMB = 1'b0,
    GRANT_CPU = 1'b1
  } grant_t;

endpackage

// File: rtl/mailbox_fifo.sv
// Mailbox FIFO placed beside the arbiter: one-cycle registered read data that
// shows the dequeued word, else the last enqueued word, else 0 when empty.
module mailbox_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enqueue,
  input  logic                  dequeue,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CW = $clog2(DATA_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         used;
  logic [DATA_WIDTH-1:0] last_word;
  logic                  do_enq, do_deq;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DATA_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_enq = enqueue && !clear && (used != CW'(DATA_DEPTH));
  assign do_deq = dequeue && !clear && !enqueue && (used != '0);

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      last_word <= '0;
      data_out  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      last_word <= '0;
      data_out  <= '0;
    end else if (do_deq) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= bump(rd_ptr);
      used     <= used - CW'(1);
    end else if (do_enq) begin
      data_out  <= data_in;
      last_word <= data_in;
      wr_ptr    <= bump(wr_ptr);
      used      <= used + CW'(1);
    end else begin
      data_out <= (used == '0) ? '0 : last_word;
    end
  end

endmodule

// File: rtl/mailbox_fifo_arbiter.sv
// Serialises SMBus and CPU mailbox operations onto one FIFO through an
// IDLE/ISSUE/CAPTURE handshake, round-robin on contention.
module mailbox_fifo_arbiter
  import mailbox_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1023
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_req,
  input  logic [1:0]                       s_op,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  output logic                             s_ack,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic                             s_err,
  input  logic                             c_req,
  input  logic [1:0]                       c_op,
  input  logic [DATA_WIDTH-1:0]            c_wdata,
  output logic                             c_ack,
  output logic [DATA_WIDTH-1:0]            c_rdata,
  output logic                             c_err,
  output logic                             fifo_enqueue,
  output logic                             fifo_dequeue,
  output logic                             fifo_clear,
  output logic [DATA_WIDTH-1:0]            fifo_data_in,
  input  logic [DATA_WIDTH-1:0]            fifo_data_out,
  output logic [$clog2(DATA_DEPTH+1)-1:0]  count,
  output logic                             empty,
  output logic                             full
);
  localparam int CW = $clog2(DATA_DEPTH + 1);

  state_t                state;
  grant_t                last_grant, grant, pick;
  op_t                   op_q, pick_op;
  logic [DATA_WIDTH-1:0] pick_wdata, result;
  logic                  s_live, c_live, err_q;

  assign empty = (count == '0);
  assign full  = (count == CW'(DATA_DEPTH));

  // A port whose ack shows this cycle is still holding req for the old transaction.
  assign s_live = s_req & ~s_ack;
  assign c_live = c_req & ~c_ack;
  assign result = (op_q == OP_DEQ || op_q == OP_PEEK) ? fifo_data_out : '0;

  always_comb begin
    if (s_live && c_live) pick = (last_grant == GRANT_CPU) ? GRANT_SMB : GRANT_CPU;
    else if (s_live)      pick = GRANT_SMB;
    else                  pick = GRANT_CPU;
    pick_op    = (pick == GRANT_SMB) ? op_t'(s_op) : op_t'(c_op);
    pick_wdata = (pick == GRANT_SMB) ? s_wdata : c_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_CPU;
      grant        <= GRANT_CPU;
      op_q         <= OP_PEEK;
      err_q        <= 1'b0;
      count        <= '0;
      fifo_enqueue <= 1'b0;
      fifo_dequeue <= 1'b0;
      fifo_clear   <= 1'b0;
      fifo_data_in <= '0;
      s_ack        <= 1'b0;
      s_rdata      <= '0;
      s_err        <= 1'b0;
      c_ack        <= 1'b0;
      c_rdata      <= '0;
      c_err        <= 1'b0;
    end else begin
      fifo_enqueue <= 1'b0;
      fifo_dequeue <= 1'b0;
      fifo_clear   <= 1'b0;
      s_ack        <= 1'b0;
      s_rdata      <= '0;
      s_err        <= 1'b0;
      c_ack        <= 1'b0;
      c_rdata      <= '0;
      c_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (s_live || c_live) begin
            grant        <= pick;
            last_grant   <= pick;
            op_q         <= pick_op;
            fifo_data_in <= pick_wdata;
            fifo_enqueue <= (pick_op == OP_ENQ);
            fifo_dequeue <= (pick_op == OP_DEQ);
            fifo_clear   <= (pick_op == OP_CLR);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // Full/empty are judged here, before this op moves the count.
          err_q <= (op_q == OP_ENQ && full) || (op_q == OP_DEQ && empty);
          case (op_q)
            OP_ENQ:  if (!full)  count <= count + CW'(1);
            OP_DEQ:  if (!empty) count <= count - CW'(1);
            OP_CLR:  count <= '0;
            default: ;
          endcase
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (grant == GRANT_SMB) begin
            s_ack   <= 1'b1;
            s_rdata <= result;
            s_err   <= err_q;
          end else begin
            c_ack   <= 1'b1;
            c_rdata <= result;
            c_err   <= err_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
